// File: rtl/prior_state_serial.sv
// Serial Kalman predict step: x_prior = F*x_post + G*u.
// Two signed multipliers, one row per two cycles, five-cycle cadence.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module prior_state_serial #(
   parameter int N    = `FXP_N,
   parameter int FRAC = `FXP_FRAC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic signed [N-1:0] x00_post,
   input  logic signed [N-1:0] x10_post,
   input  logic signed [N-1:0] f00,
   input  logic signed [N-1:0] f01,
   input  logic signed [N-1:0] f10,
   input  logic signed [N-1:0] f11,
   input  logic signed [N-1:0] g00,
   input  logic signed [N-1:0] g10,
   input  logic signed [N-1:0] u00,
   output logic                busy,
   output logic                done,
   output logic signed [N-1:0] X00_prior,
   output logic signed [N-1:0] X10_prior
);

   typedef enum logic [2:0] {IDLE, R0A, R0B, R1A, R1B} state_t;

   state_t state_q;

   logic signed [N-1:0]   x00_q, x10_q;
   logic signed [N-1:0]   f00_q, f01_q, f10_q, f11_q;
   logic signed [N-1:0]   g00_q, g10_q, u00_q;
   logic signed [2*N-1:0] acc_q;
   logic signed [N-1:0]   X00_q, X10_q;
   logic                  done_q;

   logic signed [N-1:0]   ma_a, ma_b, mb_a, mb_b;
   logic signed [2*N-1:0] p0, p1, sum_d;

   // Select multiplier operands for the current phase and form the 2N-bit sum
   always_comb begin
      ma_a  = f00_q;
      ma_b  = x00_q;
      mb_a  = f01_q;
      mb_b  = x10_q;
      unique case (state_q)
         R0B: begin
            ma_a = g00_q;
            ma_b = u00_q;
         end
         R1A: begin
            ma_a = f10_q;
            mb_a = f11_q;
         end
         R1B: begin
            ma_a = g10_q;
            ma_b = u00_q;
         end
         default: ;
      endcase
      p0 = (2*N)'(ma_a) * (2*N)'(ma_b);
      p1 = (2*N)'(mb_a) * (2*N)'(mb_b);
      if (state_q == R0A || state_q == R1A)
         sum_d = p0 + p1;
      else
         sum_d = acc_q + p0;
   end

   // Sequencer, operand capture, accumulator and registered results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x00_q   <= '0;
         x10_q   <= '0;
         f00_q   <= '0;
         f01_q   <= '0;
         f10_q   <= '0;
         f11_q   <= '0;
         g00_q   <= '0;
         g10_q   <= '0;
         u00_q   <= '0;
         acc_q   <= '0;
         X00_q   <= '0;
         X10_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  x00_q   <= x00_post;
                  x10_q   <= x10_post;
                  f00_q   <= f00;
                  f01_q   <= f01;
                  f10_q   <= f10;
                  f11_q   <= f11;
                  g00_q   <= g00;
                  g10_q   <= g10;
                  u00_q   <= u00;
                  state_q <= R0A;
               end
            end
            R0A: begin
               acc_q   <= sum_d;
               state_q <= R0B;
            end
            R0B: begin
               X00_q   <= sum_d[FRAC+N-1:FRAC];
               state_q <= R1A;
            end
            R1A: begin
               acc_q   <= sum_d;
               state_q <= R1B;
            end
            R1B: begin
               X10_q   <= sum_d[FRAC+N-1:FRAC];
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign X00_prior = X00_q;
   assign X10_prior = X10_q;

endmodule

// File: tb/tb_prior_state_serial.sv
// Directed bench for prior_state_serial (N=16, FRAC=8).
// Each scenario task drives its own stimulus and checks inline.
module tb_prior_state_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] x00_post, x10_post;
   logic [15:0] f00, f01, f10, f11;
   logic [15:0] g00, g10, u00;
   logic        busy, done;
   logic [15:0] X00_prior, X10_prior;

   int n_chk;
   int n_fail;

   prior_state_serial #(.N(16), .FRAC(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .x00_post  (x00_post),
      .x10_post  (x10_post),
      .f00       (f00),
      .f01       (f01),
      .f10       (f10),
      .f11       (f11),
      .g00       (g00),
      .g10       (g10),
      .u00       (u00),
      .busy      (busy),
      .done      (done),
      .X00_prior (X00_prior),
      .X10_prior (X10_prior)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic [15:0] a00, a01, a10, a11,
                         input logic [15:0] px0, px1,
                         input logic [15:0] pg0, pg1, pu);
      f00 = a00; f01 = a01; f10 = a10; f11 = a11;
      x00_post = px0; x10_post = px1;
      g00 = pg0; g10 = pg1; u00 = pu;
   endtask

   // Pulse start for one cycle and record observations over 8 cycles.
   // Sample c is taken at the falling edge after rising edge E_c.
   task automatic run_op(output int dpos, output int dcnt,
                         output logic [15:0] x00_c1, x00_c2,
                         output logic [15:0] x10_c3, x10_c4,
                         output logic b0, b4);
      dpos = -1;
      dcnt = 0;
      start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) begin
            start = 1'b0;
            b0 = busy;
            set_in(16'h1111, 16'h2222, 16'h3333, 16'h4444,
                   16'h5555, 16'h6666, 16'h7777, 16'h0888, 16'h0999);
         end
         if (c == 1) x00_c1 = X00_prior;
         if (c == 2) x00_c2 = X00_prior;
         if (c == 3) x10_c3 = X10_prior;
         if (c == 4) begin
            x10_c4 = X10_prior;
            b4 = busy;
         end
         if (done) begin
            dcnt++;
            if (dpos < 0) dpos = c;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b1;
      set_in(16'h0100, 0, 0, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0);
      repeat (3) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done got %b want 0", done);
      end
      n_chk++;
      if (X00_prior !== 16'h0000 || X10_prior !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_out got %h/%h want 0000/0000",
                  X00_prior, X10_prior);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored busy got %b want 0", busy);
      end
   endtask

   task automatic check_op(input string nm,
                           input logic [15:0] old00, old10,
                           input logic [15:0] e00, e10);
      int dpos, dcnt;
      logic [15:0] a1, a2, b3, b4v;
      logic bz0, bz4;
      run_op(dpos, dcnt, a1, a2, b3, b4v, bz0, bz4);
      n_chk++;
      if (a2 !== e00) begin
         n_fail++;
         $display("FAIL %s_x00 got %h want %h", nm, a2, e00);
      end
      n_chk++;
      if (b4v !== e10) begin
         n_fail++;
         $display("FAIL %s_x10 got %h want %h", nm, b4v, e10);
      end
      n_chk++;
      if (a1 !== old00 || b3 !== old10) begin
         n_fail++;
         $display("FAIL %s_hold got %h/%h want %h/%h",
                  nm, a1, b3, old00, old10);
      end
      n_chk++;
      if (dpos != 4 || dcnt != 1) begin
         n_fail++;
         $display("FAIL %s_done got pos %0d cnt %0d want pos 4 cnt 1",
                  nm, dpos, dcnt);
      end
      n_chk++;
      if (bz0 !== 1'b1 || bz4 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy got %b/%b want 1/0", nm, bz0, bz4);
      end
   endtask

   task automatic test_identity;
      @(negedge clk);
      set_in(16'h0100, 0, 0, 16'h0100, 16'h0200, 16'hFF00, 0, 0, 0);
      check_op("identity", 16'h0000, 16'h0000, 16'h0200, 16'hFF00);
   endtask

   task automatic test_const_vel;
      @(negedge clk);
      set_in(16'h0100, 16'h0100, 0, 16'h0100,
             16'h0200, 16'h0080, 0, 0, 0);
      check_op("constvel", 16'h0200, 16'hFF00, 16'h0280, 16'h0080);
   endtask

   task automatic test_control;
      @(negedge clk);
      set_in(16'h0100, 0, 0, 16'h0100, 0, 0,
             16'h0080, 16'h0100, 16'h0200);
      check_op("control", 16'h0280, 16'h0080, 16'h0100, 16'h0200);
   endtask

   task automatic test_trunc;
      @(negedge clk);
      set_in(16'h0080, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
      check_op("trunc", 16'h0100, 16'h0200, 16'hFFFF, 16'h0000);
   endtask

   task automatic test_back_to_back;
      int p0, p1, cnt;
      logic [15:0] r00, r10;
      p0 = -1; p1 = -1; cnt = 0;
      r00 = 16'hxxxx; r10 = 16'hxxxx;
      @(negedge clk);
      set_in(16'h0100, 0, 0, 16'h0100, 16'h0200, 16'hFF00, 0, 0, 0);
      start = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 0)
            set_in(16'h0100, 0, 0, 16'h0100,
                   16'h0100, 16'h0100, 0, 0, 0);
         if (c == 9) start = 1'b0;
         if (c == 4) begin
            r00 = X00_prior;
            r10 = X10_prior;
         end
         if (done) begin
            cnt++;
            if (p0 < 0) p0 = c;
            else if (p1 < 0) p1 = c;
         end
      end
      n_chk++;
      if (cnt != 2) begin
         n_fail++;
         $display("FAIL b2b_count got %0d want 2", cnt);
      end
      n_chk++;
      if (p0 != 4 || p1 != 9) begin
         n_fail++;
         $display("FAIL b2b_spacing got %0d,%0d want 4,9", p0, p1);
      end
      n_chk++;
      if (r00 !== 16'h0200 || r10 !== 16'hFF00) begin
         n_fail++;
         $display("FAIL b2b_first got %h/%h want 0200/ff00", r00, r10);
      end
      n_chk++;
      if (X00_prior !== 16'h0100 || X10_prior !== 16'h0100) begin
         n_fail++;
         $display("FAIL b2b_second got %h/%h want 0100/0100",
                  X00_prior, X10_prior);
      end
   endtask

   task automatic test_reset_mid;
      int cnt;
      cnt = 0;
      @(negedge clk);
      set_in(16'h0100, 0, 0, 16'h0100, 16'h0300, 16'h0400, 0, 0, 0);
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         if (c == 2) begin
            n_chk++;
            if (X00_prior !== 16'h0300) begin
               n_fail++;
               $display("FAIL midrst_pre got %h want 0300", X00_prior);
            end
            rst_n = 1'b0;
         end
         if (c == 3) begin
            rst_n = 1'b1;
            n_chk++;
            if (busy !== 1'b0 || X00_prior !== 16'h0000 ||
                X10_prior !== 16'h0000) begin
               n_fail++;
               $display("FAIL midrst_clear got %b %h/%h want 0 0000/0000",
                        busy, X00_prior, X10_prior);
            end
         end
         if (done) cnt++;
      end
      n_chk++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL midrst_nodone got %0d pulses want 0", cnt);
      end
      @(negedge clk);
      set_in(16'h0100, 0, 0, 16'h0100, 16'h0200, 16'hFF00, 0, 0, 0);
      check_op("midrst_fresh", 16'h0000, 16'h0000, 16'h0200, 16'hFF00);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset;
      test_identity;
      test_const_vel;
      test_control;
      test_trunc;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prior_state_serial.md
PRIOR_STATE_SERIAL -- requirements
Module: prior_state_serial

Interface
REQ-001 SHALL have parameter N, default `FXP_N, total fixed-point word width in bits.
REQ-002 SHALL have parameter FRAC, default `FXP_FRAC, number of fraction bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a prediction.
REQ-006 SHALL have ports x00_post, x10_post  input  N signed each  posterior state vector.
REQ-007 SHALL have ports f00, f01, f10, f11  input  N signed each  state transition matrix F (f01 = F row0 col1).
REQ-008 SHALL have ports g00, g10  input  N signed each  control input column G.
REQ-009 SHALL have port u00  input  N signed  scalar control input u.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports X00_prior, X10_prior  output  N signed each  predicted state x_prior = F*x_post + G*u.

Function
REQ-013 SHALL implement states IDLE, R0A, R0B, R1A, R1B, with transitions IDLE->R0A on start, then R0A->R0B->R1A->R1B->IDLE unconditionally.
REQ-014 SHALL, on the edge where start=1 in IDLE, latch all of x*, f*, g*, u00 into holding registers, so input changes afterwards do not affect the result.
REQ-015 SHALL, in R0A, load a 2N accumulator with f00*x00_post + f01*x10_post, using two N x N signed multipliers with full 2N-bit products.
REQ-016 SHALL, in R0B, register X00_prior = trunc(acc + g00*u00).
REQ-017 SHALL, in R1A, load the accumulator with f10*x00_post + f11*x10_post.
REQ-018 SHALL, in R1B, register X10_prior = trunc(acc + g10*u00) and assert done for that one cycle.
REQ-019 SHALL define trunc as 2N-bit bits [FRAC+N-1:FRAC], with no rounding (floor toward minus infinity) and no saturation.
REQ-020 SHALL add in 2N-bit two's complement with modular wrap and no overflow flag.
REQ-021 SHALL meet a latency where, with start sampled at edge E0, X00_prior updates at E2, X10_prior updates at E4, and done=1 during the cycle after E4 only.
REQ-022 SHALL ignore start while busy=1, including start asserted in the R1B cycle; the block is re-accepted from IDLE on the following cycle.
REQ-023 SHALL sustain back-to-back operation of one result per 5 cycles.
REQ-024 SHALL hold X00_prior and X10_prior stable between updates; X00_prior changes before X10_prior within an operation.
REQ-025 SHALL drive busy combinationally from state (busy = state != IDLE).

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, force state to IDLE, done to 0, X00_prior and X10_prior to 0, and accumulator and holding registers to 0.
REQ-027 SHALL, on reset mid-operation, abort with no done pulse; outputs already written are cleared to 0.
REQ-028 SHALL ignore start on any edge where rst_n=0.

Verification (N=16, FRAC=8)
REQ-029 SHALL cover identity: F=I (0x0100 diagonal, 0 off-diagonal), g=0, u=0, x=(0x0200, 0xFF00) -> X00_prior=0x0200, X10_prior=0xFF00, done exactly 5 cycles after start.
REQ-030 SHALL cover constant velocity: f00=f01=f11=0x0100, f10=0, x=(0x0200, 0x0080), g=0 -> X00_prior=0x0280, X10_prior=0x0080.
REQ-031 SHALL cover control: F=I, x=0, g00=0x0080, g10=0x0100, u00=0x0200 -> X00_prior=0x0100, X10_prior=0x0200.
REQ-032 SHALL cover truncation: f00=0x0080, x00_post=0xFFFF, all others 0 -> X00_prior=0xFFFF, X10_prior=0x0000.
REQ-033 SHALL cover start in each busy cycle: start held high for 10 cycles -> exactly 2 done pulses, 5 cycles apart; inputs changed after E0 do not alter the first result.
REQ-034 SHALL cover reset mid-operation: rst_n=0 in state R1A -> no done pulse, outputs 0, and a fresh start completes normally.
